// File: rtl/icache_dm_if.sv
// ============================================================================
// Module   : icache_dm_if
// Brief    : Fetch-side and refill-side signal bundle for icache_dm.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface icache_dm_if;
    logic        req_valid;
    logic        req_ready;
    logic [29:0] req_index;
    logic        flush;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport slave (
        input  req_valid, req_index, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
    );

    modport master (
        output req_valid, req_index, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr
    );
endinterface

`default_nettype wire

// File: rtl/icache_dm.sv
// ============================================================================
// Module   : icache_dm
// Brief    : Direct-mapped instruction cache, 1-cycle hit, line refill, 1-cycle
//            flush. Define ICACHE_PERF_EN to add hit/miss counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache_dm #(
    parameter int          LINE_WORDS = 4,
    parameter int          NUM_LINES  = 64,
    parameter logic [31:0] RESET_WORD = 32'h0000_0013
) (
    input  wire logic     clk,
    input  wire logic     rst,
    icache_dm_if.slave    bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]   perf_hits,
    output logic [31:0]   perf_misses
`endif
);
    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TW = 30 - OB - IB;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_MISS_REQ = 3'd2,
        S_REFILL   = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [29:0]          idx_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [OB-1:0]        beat_q;
    logic                 flush_pend_q;
    logic [31:0]          addr_q;
    logic [31:0]          cap_q;
    logic [31:0]          out_q;
    logic [31:0]          rdata_q;
    logic [TW-1:0]        tag_rd_q;

    logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];
    logic [TW-1:0]        tag_mem  [NUM_LINES];

    logic [OB-1:0]        w_lk_off;
    logic [IB-1:0]        w_lk_idx;
    logic [TW-1:0]        w_lk_tag;
    logic                 w_hit;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_fill;
    logic                 w_beat_last;

    assign w_lk_off    = idx_q[OB-1:0];
    assign w_lk_idx    = idx_q[OB+IB-1:OB];
    assign w_lk_tag    = idx_q[29:OB+IB];
    assign w_hit       = valid_q[w_lk_idx] && (tag_rd_q == w_lk_tag);
    assign w_ready     = (state_q == S_IDLE) && !rst && !bus.flush && !flush_pend_q;
    assign w_accept    = w_ready && bus.req_valid;
    assign w_fill      = (state_q == S_REFILL) && bus.mem_resp_valid && !rst;
    assign w_beat_last = (beat_q == OB'(LINE_WORDS - 1));

    assign bus.req_ready    = w_ready;
    assign bus.mem_req_addr = addr_q;

    always_comb begin
        state_d           = state_q;
        bus.resp_valid    = 1'b0;
        bus.resp_data     = out_q;
        bus.mem_req_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (w_accept) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    bus.resp_valid = 1'b1;
                    bus.resp_data  = rdata_q;
                    state_d        = S_IDLE;
                end else begin
                    state_d = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = S_REFILL;
            end
            S_REFILL: begin
                if (bus.mem_resp_valid && w_beat_last) state_d = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = cap_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            valid_q      <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            addr_q       <= '0;
            cap_q        <= '0;
            out_q        <= RESET_WORD;
        end else begin
            state_q <= state_d;
            if (bus.resp_valid) out_q <= bus.resp_data;
            // A flush seen mid-transaction is deferred until the FSM is back in IDLE.
            if (state_q == S_IDLE) begin
                if (bus.flush || flush_pend_q) begin
                    valid_q      <= '0;
                    flush_pend_q <= 1'b0;
                end
                if (w_accept) idx_q <= bus.req_index;
            end else if (bus.flush) begin
                flush_pend_q <= 1'b1;
            end
            case (state_q)
                S_LOOKUP: begin
                    if (!w_hit) begin
                        valid_q[w_lk_idx] <= 1'b0;
                        addr_q            <= {w_lk_tag, w_lk_idx, {(OB+2){1'b0}}};
                    end
                end
                S_MISS_REQ: begin
                    if (bus.mem_req_ready) beat_q <= '0;
                end
                S_REFILL: begin
                    if (bus.mem_resp_valid) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == w_lk_off) cap_q <= bus.mem_resp_data;
                        if (w_beat_last && !flush_pend_q && !bus.flush) valid_q[w_lk_idx] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Arrays carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            rdata_q  <= data_mem[bus.req_index[OB+IB-1:0]];
            tag_rd_q <= tag_mem[bus.req_index[OB+IB-1:OB]];
        end
        if (w_fill) begin
            data_mem[{w_lk_idx, beat_q}] <= bus.mem_resp_data;
            if (w_beat_last) tag_mem[w_lk_idx] <= w_lk_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hits_q, perf_misses_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else if (state_q == S_LOOKUP) begin
            if (w_hit) begin
                if (perf_hits_q != 32'hFFFF_FFFF) perf_hits_q <= perf_hits_q + 32'd1;
            end else begin
                if (perf_misses_q != 32'hFFFF_FFFF) perf_misses_q <= perf_misses_q + 32'd1;
            end
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_dm.sv
// ============================================================================
// Module   : tb_icache_dm
// Brief    : Randomised scoreboard bench for icache_dm (ICACHE_PERF_EN aware).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_icache_dm;
    localparam int          LW         = 4;
    localparam int          NL         = 64;
    localparam logic [31:0] RESET_WORD = 32'h0000_0013;

    typedef struct {
        logic [31:0] data;
        bit          hit;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    icache_dm_if bus();
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hits, perf_misses;
`endif

    icache_dm #(.LINE_WORDS(LW), .NUM_LINES(NL), .RESET_WORD(RESET_WORD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hits(perf_hits),
        .perf_misses(perf_misses)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mv   [NL];
    int          mtag [NL];
    int          m_hits = 0;
    int          m_misses = 0;
    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] ovr [logic [31:0]];
    int          beats_sent = 0;
    bit          mem_busy = 1'b0;
    int          last_beat_cyc = 0;
    bit          rand_flush = 1'b0;
    bit          ready_rand = 1'b0;
    bit          gap_rand = 1'b0;
    bit          stray_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Backing memory: directed overrides, otherwise a fixed hash of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_clear();
        foreach (mv[i]) mv[i] = 1'b0;
    endtask

    task automatic model_lookup(input logic [29:0] idx);
        longint word = longint'(idx);
        int     line = int'((word / LW) % NL);
        int     tag  = int'(word / (LW * NL));
        exp_t   e;
        e.data    = mem_word(32'(word * 4));
        e.hit     = mv[line] && (mtag[line] == tag);
        e.acc_cyc = cyc + 1;
        if (e.hit) begin
            m_hits++;
        end else begin
            m_misses++;
            mv[line]   = 1'b1;
            mtag[line] = tag;
            addr_q.push_back(32'((word / LW) * LW * 4));
        end
        exp_q.push_back(e);
    endtask

    task automatic tick(input bit force_flush);
        @(negedge clk);
        bus.flush = force_flush || (rand_flush && ($urandom_range(0, 29) == 0));
        if (bus.flush) model_clear();
    endtask

    task automatic do_req(input logic [29:0] idx);
        int n;
        bit acc;
        tick(1'b0);
        bus.req_valid = 1'b1;
        bus.req_index = idx;
        n   = 0;
        acc = 1'b0;
        while (!acc && n <= 200) begin
            #1;
            if (bus.req_ready) begin
                acc = 1'b1;
                model_lookup(idx);
            end else begin
                n++;
                tick(1'b0);
            end
        end
        if (!acc) fail_now("req_accept_timeout");
        tick(1'b0);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0 || mem_busy) && n < 500) begin
            tick(1'b0);
            n++;
        end
        if (n == 500) begin
            fail_now("idle_timeout");
            exp_q.delete();
            addr_q.delete();
        end
        tick(1'b0);
        tick(1'b0);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (beats_sent < target && n < 200) begin
            tick(1'b0);
            n++;
        end
        if (n == 200) fail_now("beat_wait_timeout");
    endtask

    // Backing memory responder: checks the refill address, then streams the line.
    initial begin : mem_model
        logic [31:0] line_addr;
        int w;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            bus.mem_req_ready  = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.mem_resp_valid = stray_rand && ($urandom_range(0, 7) == 0);
            bus.mem_resp_data  = $urandom();
            #1;
            if (!rst && bus.mem_req_valid) begin
                if (addr_q.size() == 0) fail_now("unexpected_mem_req");
                else check("mem_req_addr", bus.mem_req_addr, addr_q[0]);
                if (bus.mem_req_ready) begin
                    if (addr_q.size() != 0) void'(addr_q.pop_front());
                    line_addr = bus.mem_req_addr;
                    mem_busy  = 1'b1;
                    w = 0;
                    while (w < LW) begin
                        @(negedge clk);
                        bus.mem_req_ready  = 1'b0;
                        bus.mem_resp_valid = gap_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
                        if (bus.mem_resp_valid) begin
                            bus.mem_resp_data = mem_word(line_addr + 32'(4 * w));
                            w++;
                            beats_sent++;
                            if (w == LW) last_beat_cyc = cyc + 1;
                        end
                    end
                    mem_busy = 1'b0;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every resp_valid pulse.
    initial begin : monitor
        exp_t        e;
        logic [31:0] last_data;
        last_data = RESET_WORD;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                last_data = RESET_WORD;
            end else if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", bus.resp_data, e.data);
                    if (e.hit) check("hit_latency", 32'(cyc), 32'(e.acc_cyc));
                    else       check("miss_resp_cycle", 32'(cyc), 32'(last_beat_cyc));
                    last_data = e.data;
                end
            end else begin
                check("resp_hold", bus.resp_data, last_data);
            end
        end
    end

    initial begin : main
        logic [29:0] ridx;
        int b0;
        bus.req_valid = 1'b0;
        bus.req_index = '0;
        bus.flush     = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) ovr[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);

        repeat (3) tick(1'b0);
        #1;
        check("ready_in_reset", 32'(bus.req_ready), 32'd0);
        tick(1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(bus.req_ready), 32'd1);
        check("resp_valid_after_reset", 32'(bus.resp_valid), 32'd0);
        check("resp_data_after_reset", bus.resp_data, RESET_WORD);
        check("mem_req_valid_after_reset", 32'(bus.mem_req_valid), 32'd0);

        // Cold miss to PC 0x100, hit on PC 0x10C, conflict at PC 0x500 and back.
        do_req(30'h040); wait_idle();
        do_req(30'h043); wait_idle();
        do_req(30'h140); wait_idle();
        do_req(30'h040); wait_idle();
`ifdef ICACHE_PERF_EN
        check("perf_hits_after_t3", perf_hits, 32'd1);
        check("perf_misses_after_t3", perf_misses, 32'd3);
`endif

        // Flush in IDLE, then a flush landing mid-refill.
        tick(1'b1);
        b0 = beats_sent;
        do_req(30'h041);
        wait_beats(b0 + 2);
        tick(1'b1);
        wait_idle();
        do_req(30'h041); wait_idle();
        do_req(30'h041); wait_idle();

        // Reset abandoning a refill after its first beat; stray beats follow.
        b0 = beats_sent;
        do_req(30'h140);
        wait_beats(b0 + 1);
        tick(1'b0);
        rst = 1'b1;
        model_clear();
        exp_q.delete();
        addr_q.delete();
        m_hits   = 0;
        m_misses = 0;
        tick(1'b0);
        #1;
        check("ready_in_reset2", 32'(bus.req_ready), 32'd0);
        tick(1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_reset2", 32'(bus.req_ready), 32'd1);
        check("resp_valid_after_reset2", 32'(bus.resp_valid), 32'd0);
        check("resp_data_after_reset2", bus.resp_data, RESET_WORD);
        wait_idle();
        do_req(30'h040); wait_idle();

        // Randomised traffic: random flushes, handshake stalls, beat gaps, stray beats.
        rand_flush = 1'b1;
        ready_rand = 1'b1;
        gap_rand   = 1'b1;
        stray_rand = 1'b1;
        repeat (300) begin
            ridx = 30'($urandom_range(0, 2) * LW * NL + ($urandom_range(0, 5) + 8) * LW
                       + $urandom_range(0, LW - 1));
            do_req(ridx);
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        rand_flush = 1'b0;
        stray_rand = 1'b0;
        wait_idle();
`ifdef ICACHE_PERF_EN
        check("perf_hits_final", perf_hits, 32'(m_hits));
        check("perf_misses_final", perf_misses, 32'(m_misses));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
